axi4_addr_router: RTL and testbench

//  Parametrised 1-to-NUM_SLV AXI4 address router for the chipset AXI fabric.

---
 rtl/axi4_addr_router_if.sv | 47 ++++
 rtl/axi4_addr_router.sv | 234 +++++++++++++++++++++++
 tb/tb_axi4_addr_router.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_addr_router_if.sv
// axi4_addr_router_if
//   Bundles the five AXI4 channels (AW, W, B, AR, R) as payload/valid/ready
//   triples. N is the number of valid/ready lanes: 1 for the upstream port,
//   NUM_SLV for the fanned-out downstream side. AW/W/AR payloads are shared
//   across lanes; B/R payloads are packed one slice per lane.
//   master modport: drives AW/W/AR and the B/R readies.
//   slave modport:  drives B/R and the AW/W/AR readies.
interface axi4_addr_router_if #(
  parameter int N    = 1,
  parameter int ID_W = 6,
  parameter int AW_W = 64 + ID_W + 8 + 3 + 2,
  parameter int W_W  = 512 + 64 + 1,
  parameter int R_W  = 512 + 2 + 1 + ID_W,
  parameter int B_W  = 2 + ID_W
);
  logic [AW_W-1:0]  aw_pl;
  logic [N-1:0]     aw_valid;
  logic [N-1:0]     aw_ready;
  logic [W_W-1:0]   w_pl;
  logic [N-1:0]     w_valid;
  logic [N-1:0]     w_ready;
  logic [N*B_W-1:0] b_pl;
  logic [N-1:0]     b_valid;
  logic [N-1:0]     b_ready;
  logic [AW_W-1:0]  ar_pl;
  logic [N-1:0]     ar_valid;
  logic [N-1:0]     ar_ready;
  logic [N*R_W-1:0] r_pl;
  logic [N-1:0]     r_valid;
  logic [N-1:0]     r_ready;

  modport master (
    output aw_pl, aw_valid, input aw_ready,
    output w_pl, w_valid, input w_ready,
    input b_pl, b_valid, output b_ready,
    output ar_pl, ar_valid, input ar_ready,
    input r_pl, r_valid, output r_ready
  );

  modport slave (
    input aw_pl, aw_valid, output aw_ready,
    input w_pl, w_valid, output w_ready,
    output b_pl, b_valid, input b_ready,
    input ar_pl, ar_valid, output ar_ready,
    output r_pl, r_valid, input r_ready
  );
endinterface

// File: rtl/axi4_addr_router.sv
// axi4_addr_router
//   1-to-NUM_SLV AXI4 address router. One upstream slave port is fanned out
//   to NUM_SLV downstream master ports by address decode. Each direction keeps
//   an outstanding counter and a locked target, so all in-flight transactions
//   of a direction go to one port and AXI ordering holds without ID remapping.
//   Unmapped addresses are answered internally with DECERR.
// Ports
//   chipset_clk   clock
//   chipset_rstn  asynchronous active-low reset
//   s             upstream port (slave modport, 1 lane)
//   m             downstream ports (master modport, NUM_SLV lanes)
module axi4_addr_router #(
  parameter int NUM_SLV  = 5,
  parameter int ADDR_W   = 64,
  parameter int ID_W     = 6,
  parameter int AW_W     = ADDR_W + ID_W + 8 + 3 + 2,
  parameter int W_W      = 512 + 64 + 1,
  parameter int R_W      = 512 + 2 + 1 + ID_W,
  parameter int B_W      = 2 + ID_W,
  parameter logic [NUM_SLV*ADDR_W-1:0] BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] MASK = '0,
  parameter int MAX_OUTS = 8
) (
  input logic chipset_clk,
  input logic chipset_rstn,
  axi4_addr_router_if.slave  s,
  axi4_addr_router_if.master m
);
  localparam int TW = $clog2(NUM_SLV + 1);
  localparam int CW = $clog2(MAX_OUTS + 1);
  localparam int PW = $clog2(MAX_OUTS);
  localparam logic [TW-1:0] ERR     = TW'(NUM_SLV);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTS);

  typedef enum logic [1:0] {WE_IDLE, WE_DATA, WE_RESP} we_state_t;
  typedef enum logic {RE_IDLE, RE_DATA} re_state_t;

  logic [TW-1:0] aw_tgt, ar_tgt, wr_lock, rd_lock, wf_head;
  logic [CW-1:0] wr_cnt, rd_cnt, wf_cnt;
  logic [PW-1:0] wf_wptr, wf_rptr;
  logic [TW-1:0] wf_mem [MAX_OUTS];
  logic          aw_stall, ar_stall, aw_sel_ready, ar_sel_ready, w_sel_ready;
  logic          wf_empty, wf_full;
  logic          aw_hs, ar_hs, w_hs, b_hs, r_last_hs, err_w_hs, err_r_hs;
  logic          b_sel_valid, r_sel_valid;
  logic [B_W-1:0] b_sel_pl;
  logic [R_W-1:0] r_sel_pl;
  we_state_t     we_state;
  re_state_t     re_state;
  logic [ID_W-1:0] err_wid, err_rid;
  logic [7:0]    err_rlen, err_rbeat;
  logic          err_aw_ready, err_w_ready, err_b_valid;
  logic          err_ar_ready, err_r_valid, err_rlast;

  // Lowest matching region wins; scanning downward lets it overwrite last.
  function automatic logic [TW-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [TW-1:0] t;
    t = ERR;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])
        t = TW'(i);
    return t;
  endfunction

  assign m.aw_pl = s.aw_pl;
  assign m.w_pl  = s.w_pl;
  assign m.ar_pl = s.ar_pl;

  assign err_aw_ready = (we_state == WE_IDLE);
  assign err_w_ready  = (we_state == WE_DATA);
  assign err_b_valid  = (we_state == WE_RESP);
  assign err_ar_ready = (re_state == RE_IDLE);
  assign err_r_valid  = (re_state == RE_DATA);
  assign err_rlast    = (err_rbeat == err_rlen);

  assign wf_empty = (wf_cnt == '0);
  assign wf_full  = (wf_cnt == CNT_MAX);
  assign wf_head  = wf_mem[wf_rptr];

  // Address channels: decode, stall on limit / target change / full W-route
  // FIFO, then steer valid to the target and ready back from it. Reset forces
  // every valid/ready low immediately.
  always_comb begin
    aw_tgt = decode(s.aw_pl[ADDR_W-1:0]);
    ar_tgt = decode(s.ar_pl[ADDR_W-1:0]);
    aw_stall = !chipset_rstn || (wr_cnt == CNT_MAX) || wf_full ||
               ((wr_cnt != '0) && (aw_tgt != wr_lock));
    ar_stall = !chipset_rstn || (rd_cnt == CNT_MAX) ||
               ((rd_cnt != '0) && (ar_tgt != rd_lock));
    aw_sel_ready = (aw_tgt == ERR) && err_aw_ready;
    ar_sel_ready = (ar_tgt == ERR) && err_ar_ready;
    m.aw_valid = '0;
    m.ar_valid = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (aw_tgt == TW'(i)) begin
        m.aw_valid[i] = s.aw_valid && !aw_stall;
        aw_sel_ready  = m.aw_ready[i];
      end
      if (ar_tgt == TW'(i)) begin
        m.ar_valid[i] = s.ar_valid && !ar_stall;
        ar_sel_ready  = m.ar_ready[i];
      end
    end
    s.aw_ready = aw_sel_ready && !aw_stall;
    s.ar_ready = ar_sel_ready && !ar_stall;
  end

  // W beats follow the head of the W-route FIFO; empty FIFO blocks W.
  always_comb begin
    w_sel_ready = (wf_head == ERR) && err_w_ready;
    m.w_valid = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (wf_head == TW'(i)) begin
        m.w_valid[i] = s.w_valid && !wf_empty && chipset_rstn;
        w_sel_ready  = m.w_ready[i];
      end
    end
    s.w_ready = w_sel_ready && !wf_empty && chipset_rstn;
  end

  // Response channels: only the locked target is muxed upstream, and only
  // while something is outstanding in that direction.
  always_comb begin
    b_sel_valid = (wr_lock == ERR) && err_b_valid;
    b_sel_pl    = {err_wid, 2'b11};
    r_sel_valid = (rd_lock == ERR) && err_r_valid;
    r_sel_pl    = {{(R_W-ID_W-3){1'b0}}, err_rid, 2'b11, err_rlast};
    m.b_ready = '0;
    m.r_ready = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (wr_lock == TW'(i)) begin
        b_sel_valid  = m.b_valid[i];
        b_sel_pl     = m.b_pl[i*B_W +: B_W];
        m.b_ready[i] = s.b_ready && (wr_cnt != '0) && chipset_rstn;
      end
      if (rd_lock == TW'(i)) begin
        r_sel_valid  = m.r_valid[i];
        r_sel_pl     = m.r_pl[i*R_W +: R_W];
        m.r_ready[i] = s.r_ready && (rd_cnt != '0) && chipset_rstn;
      end
    end
    s.b_valid = b_sel_valid && (wr_cnt != '0) && chipset_rstn;
    s.b_pl    = b_sel_pl;
    s.r_valid = r_sel_valid && (rd_cnt != '0) && chipset_rstn;
    s.r_pl    = r_sel_pl;
  end

  assign aw_hs     = s.aw_valid && s.aw_ready;
  assign ar_hs     = s.ar_valid && s.ar_ready;
  assign w_hs      = s.w_valid && s.w_ready;
  assign b_hs      = s.b_valid && s.b_ready;
  assign r_last_hs = s.r_valid && s.r_ready && s.r_pl[0];
  assign err_w_hs  = w_hs && (wf_head == ERR);
  assign err_r_hs  = s.r_valid && s.r_ready && (rd_lock == ERR);

  // Outstanding counters and locked targets; the lock is only reloaded when
  // the direction is fully drained.
  always_ff @(posedge chipset_clk or negedge chipset_rstn) begin
    if (!chipset_rstn) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_lock <= '0;
      rd_lock <= '0;
    end else begin
      if (aw_hs && !b_hs)      wr_cnt <= wr_cnt + CW'(1);
      else if (b_hs && !aw_hs) wr_cnt <= wr_cnt - CW'(1);
      if (ar_hs && !r_last_hs)      rd_cnt <= rd_cnt + CW'(1);
      else if (r_last_hs && !ar_hs) rd_cnt <= rd_cnt - CW'(1);
      if (aw_hs && (wr_cnt == '0)) wr_lock <= aw_tgt;
      if (ar_hs && (rd_cnt == '0)) rd_lock <= ar_tgt;
    end
  end

  // W-route FIFO pointers and occupancy; push on AW, pop on wlast.
  always_ff @(posedge chipset_clk or negedge chipset_rstn) begin
    if (!chipset_rstn) begin
      wf_wptr <= '0;
      wf_rptr <= '0;
      wf_cnt  <= '0;
    end else begin
      if (aw_hs) wf_wptr <= wf_wptr + PW'(1);
      if (w_hs && s.w_pl[0]) wf_rptr <= wf_rptr + PW'(1);
      if (aw_hs && !(w_hs && s.w_pl[0]))      wf_cnt <= wf_cnt + CW'(1);
      else if (!aw_hs && (w_hs && s.w_pl[0])) wf_cnt <= wf_cnt - CW'(1);
    end
  end

  // FIFO storage needs no reset: entries are only read once pushed.
  always_ff @(posedge chipset_clk) begin
    if (aw_hs) wf_mem[wf_wptr] <= aw_tgt;
  end

  // Error write engine: take one unmapped AW, sink its W burst, answer DECERR.
  always_ff @(posedge chipset_clk or negedge chipset_rstn) begin
    if (!chipset_rstn) begin
      we_state <= WE_IDLE;
      err_wid  <= '0;
    end else begin
      unique case (we_state)
        WE_IDLE: if (aw_hs && (aw_tgt == ERR)) begin
          err_wid  <= s.aw_pl[ADDR_W +: ID_W];
          we_state <= WE_DATA;
        end
        WE_DATA: if (err_w_hs && s.w_pl[0]) we_state <= WE_RESP;
        WE_RESP: if (b_hs && (wr_lock == ERR)) we_state <= WE_IDLE;
        default: we_state <= WE_IDLE;
      endcase
    end
  end

  // Error read engine: take one unmapped AR, return len+1 zero-data DECERR beats.
  always_ff @(posedge chipset_clk or negedge chipset_rstn) begin
    if (!chipset_rstn) begin
      re_state  <= RE_IDLE;
      err_rid   <= '0;
      err_rlen  <= '0;
      err_rbeat <= '0;
    end else begin
      unique case (re_state)
        RE_IDLE: if (ar_hs && (ar_tgt == ERR)) begin
          err_rid   <= s.ar_pl[ADDR_W +: ID_W];
          err_rlen  <= s.ar_pl[ADDR_W+ID_W +: 8];
          err_rbeat <= '0;
          re_state  <= RE_DATA;
        end
        RE_DATA: if (err_r_hs) begin
          if (err_rlast) re_state <= RE_IDLE;
          else           err_rbeat <= err_rbeat + 8'd1;
        end
        default: re_state <= RE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_addr_router.sv
// tb_axi4_addr_router
//   Directed bench for axi4_addr_router with five mapped regions:
//   port0 0x0xxx-0x3xxx, port1 0x8xxx-0xBxxx, port2 0x4xxx, port3 0x5xxx,
//   port4 0x6xxx (top nibble of the low 32 bits); 0x7xxx and 0xCxxx-0xFxxx
//   are unmapped.
module tb_axi4_addr_router;
  localparam int NUM_SLV = 5;
  localparam int ADDR_W  = 64;
  localparam int ID_W    = 6;
  localparam int AW_W    = ADDR_W + ID_W + 8 + 3 + 2;
  localparam int W_W     = 512 + 64 + 1;
  localparam int R_W     = 512 + 2 + 1 + ID_W;
  localparam int B_W     = 2 + ID_W;
  localparam logic [NUM_SLV*ADDR_W-1:0] BASE =
    {64'h6000_0000, 64'h5000_0000, 64'h4000_0000, 64'h8000_0000, 64'h0};
  localparam logic [NUM_SLV*ADDR_W-1:0] MASK =
    {64'hF000_0000, 64'hF000_0000, 64'hF000_0000, 64'hC000_0000, 64'hC000_0000};

  logic chipset_clk;
  logic chipset_rstn;
  int   n_checks;
  int   n_fail;

  axi4_addr_router_if #(.N(1), .ID_W(ID_W)) up ();
  axi4_addr_router_if #(.N(NUM_SLV), .ID_W(ID_W)) dn ();

  axi4_addr_router #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .ID_W(ID_W),
    .BASE(BASE), .MASK(MASK), .MAX_OUTS(8)
  ) dut (
    .chipset_clk(chipset_clk),
    .chipset_rstn(chipset_rstn),
    .s(up),
    .m(dn)
  );

  initial chipset_clk = 1'b0;
  always #5 chipset_clk = ~chipset_clk;

  function automatic logic [AW_W-1:0] mk_ax(input logic [63:0] addr, input logic [5:0] id,
                                            input logic [7:0] len);
    return {5'b0, len, id, addr};
  endfunction

  function automatic logic [W_W-1:0] mk_w(input logic [63:0] data, input logic last);
    return {{(W_W-65){1'b0}}, data, last};
  endfunction

  function automatic logic [R_W-1:0] mk_r(input logic [5:0] id, input logic [1:0] resp,
                                          input logic last);
    return {{(R_W-ID_W-3){1'b0}}, id, resp, last};
  endfunction

  task automatic tick();
    @(posedge chipset_clk);
    #1;
  endtask

  task automatic test_reset();
    chipset_rstn = 1'b0;
    dn.aw_ready = '1; dn.w_ready = '1; dn.ar_ready = '1;
    dn.b_valid = '1; dn.r_valid = '1;
    up.aw_pl = mk_ax(64'h8000_0040, 6'h01, 8'd0); up.aw_valid = 1'b1;
    up.ar_pl = mk_ax(64'h0000_1000, 6'h02, 8'd0); up.ar_valid = 1'b1;
    up.b_ready = 1'b1; up.r_ready = 1'b1;
    #3;
    n_checks++; if ({up.aw_ready, up.ar_ready, up.w_ready} !== 3'b000) begin n_fail++;
      $display("[TB] FAIL rst_s_ready: got %b expected 000", {up.aw_ready, up.ar_ready, up.w_ready}); end
    n_checks++; if ({up.b_valid, up.r_valid} !== 2'b00) begin n_fail++;
      $display("[TB] FAIL rst_s_valid: got %b expected 00", {up.b_valid, up.r_valid}); end
    n_checks++; if ({dn.aw_valid, dn.ar_valid} !== 10'b0) begin n_fail++;
      $display("[TB] FAIL rst_m_valid: got %b expected 0", {dn.aw_valid, dn.ar_valid}); end
    n_checks++; if ({dn.b_ready, dn.r_ready} !== 10'b0) begin n_fail++;
      $display("[TB] FAIL rst_m_ready: got %b expected 0", {dn.b_ready, dn.r_ready}); end
    up.aw_valid = 1'b0; up.ar_valid = 1'b0; up.b_ready = 1'b0; up.r_ready = 1'b0;
    dn.b_valid = '0; dn.r_valid = '0;
    tick(); tick();
    chipset_rstn = 1'b1;
    tick();
    n_checks++; if ({dut.wr_cnt, dut.rd_cnt, dut.wf_cnt} !== 12'b0) begin n_fail++;
      $display("[TB] FAIL rst_counters: got %h expected 0", {dut.wr_cnt, dut.rd_cnt, dut.wf_cnt}); end
  endtask

  task automatic test_pass_through();
    logic [AW_W-1:0] pl;
    pl = mk_ax(64'h8000_0040, 6'h15, 8'd3);
    dn.aw_ready = '1; dn.w_ready = '1;
    up.aw_pl = pl; up.aw_valid = 1'b1;
    #1;
    n_checks++; if ({dn.aw_valid, up.aw_ready} !== 6'b00010_1) begin n_fail++;
      $display("[TB] FAIL pt_aw_route: got %b expected 000101", {dn.aw_valid, up.aw_ready}); end
    n_checks++; if (dn.aw_pl !== pl) begin n_fail++;
      $display("[TB] FAIL pt_aw_pl: got %h expected %h", dn.aw_pl, pl); end
    tick();
    up.aw_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      up.w_pl = mk_w(64'hA0 + 64'(k), (k == 3)); up.w_valid = 1'b1;
      #1;
      n_checks++; if ({dn.w_valid, up.w_ready} !== 6'b00010_1) begin n_fail++;
        $display("[TB] FAIL pt_w_beat%0d: got %b expected 000101", k, {dn.w_valid, up.w_ready}); end
      tick();
    end
    up.w_valid = 1'b0;
    #1;
    n_checks++; if (up.w_ready !== 1'b0) begin n_fail++;
      $display("[TB] FAIL pt_w_empty: got %b expected 0", up.w_ready); end
    dn.b_pl = '1; dn.b_pl[1*B_W +: B_W] = {6'h15, 2'b00};
    dn.b_valid = 5'b00010; up.b_ready = 1'b1;
    #1;
    n_checks++; if ({up.b_valid, up.b_pl} !== {1'b1, 6'h15, 2'b00}) begin n_fail++;
      $display("[TB] FAIL pt_b: got %b_%h expected 1_54", up.b_valid, up.b_pl); end
    n_checks++; if (dn.b_ready !== 5'b00010) begin n_fail++;
      $display("[TB] FAIL pt_b_ready: got %b expected 00010", dn.b_ready); end
    tick();
    dn.b_valid = '0; up.b_ready = 1'b0;
    #1;
    n_checks++; if (dut.wr_cnt !== 4'd0) begin n_fail++;
      $display("[TB] FAIL pt_wr_cnt: got %0d expected 0", dut.wr_cnt); end
  endtask

  task automatic test_unmapped_read();
    dn.ar_ready = '1; dn.r_valid = '1; dn.r_pl = '1;
    up.ar_pl = mk_ax(64'hF000_0000, 6'h2A, 8'd2); up.ar_valid = 1'b1;
    #1;
    n_checks++; if ({dn.ar_valid, up.ar_ready} !== 6'b00000_1) begin n_fail++;
      $display("[TB] FAIL ur_ar: got %b expected 000001", {dn.ar_valid, up.ar_ready}); end
    tick();
    up.ar_valid = 1'b0; up.r_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if ({up.r_valid, up.r_pl} !== {1'b1, mk_r(6'h2A, 2'b11, (k == 2))}) begin n_fail++;
        $display("[TB] FAIL ur_r_beat%0d: got v=%b id=%h low=%b", k, up.r_valid, up.r_pl[ID_W+2:3], up.r_pl[2:0]); end
      n_checks++; if (dn.r_ready !== 5'b0) begin n_fail++;
        $display("[TB] FAIL ur_r_ready%0d: got %b expected 00000", k, dn.r_ready); end
      tick();
    end
    up.r_ready = 1'b0; dn.r_valid = '0;
    #1;
    n_checks++; if ({up.r_valid, dut.rd_cnt} !== 5'b0) begin n_fail++;
      $display("[TB] FAIL ur_done: got v=%b cnt=%0d expected 0/0", up.r_valid, dut.rd_cnt); end
  endtask

  task automatic test_unmapped_write();
    dn.b_valid = '1; dn.b_pl = '1;
    up.aw_pl = mk_ax(64'h7000_0000, 6'h03, 8'd1); up.aw_valid = 1'b1;
    #1;
    n_checks++; if ({dn.aw_valid, up.aw_ready} !== 6'b00000_1) begin n_fail++;
      $display("[TB] FAIL uw_aw: got %b expected 000001", {dn.aw_valid, up.aw_ready}); end
    tick();
    up.aw_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      up.w_pl = mk_w(64'h77, (k == 1)); up.w_valid = 1'b1;
      #1;
      n_checks++; if ({dn.w_valid, up.w_ready} !== 6'b00000_1) begin n_fail++;
        $display("[TB] FAIL uw_w%0d: got %b expected 000001", k, {dn.w_valid, up.w_ready}); end
      tick();
    end
    up.w_valid = 1'b0; up.b_ready = 1'b1;
    #1;
    n_checks++; if ({up.b_valid, up.b_pl} !== {1'b1, 6'h03, 2'b11}) begin n_fail++;
      $display("[TB] FAIL uw_b: got %b_%h expected 1_0f", up.b_valid, up.b_pl); end
    tick();
    up.b_ready = 1'b0; dn.b_valid = '0;
    #1;
    n_checks++; if ({up.b_valid, dut.wr_cnt} !== 5'b0) begin n_fail++;
      $display("[TB] FAIL uw_done: got v=%b cnt=%0d expected 0/0", up.b_valid, dut.wr_cnt); end
  endtask

  task automatic test_target_switch();
    dn.aw_ready = '1; dn.w_ready = '1; dn.b_pl = '0;
    up.aw_pl = mk_ax(64'h0000_1000, 6'h01, 8'd0); up.aw_valid = 1'b1;
    #1;
    n_checks++; if (dn.aw_valid !== 5'b00001) begin n_fail++;
      $display("[TB] FAIL ts_aw0: got %b expected 00001", dn.aw_valid); end
    tick();
    up.aw_valid = 1'b0; up.w_pl = mk_w(64'h55, 1'b1); up.w_valid = 1'b1;
    #1;
    n_checks++; if (dn.w_valid !== 5'b00001) begin n_fail++;
      $display("[TB] FAIL ts_w0: got %b expected 00001", dn.w_valid); end
    tick();
    up.w_valid = 1'b0;
    up.aw_pl = mk_ax(64'h4000_0100, 6'h02, 8'd0); up.aw_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if ({dn.aw_valid, up.aw_ready} !== 6'b0) begin n_fail++;
        $display("[TB] FAIL ts_stall%0d: got %b expected 000000", k, {dn.aw_valid, up.aw_ready}); end
      tick();
    end
    dn.b_pl[0 +: B_W] = {6'h01, 2'b00}; dn.b_valid = 5'b00001; up.b_ready = 1'b1;
    #1;
    n_checks++; if ({up.b_valid, up.aw_ready} !== 2'b10) begin n_fail++;
      $display("[TB] FAIL ts_b0: got %b expected 10", {up.b_valid, up.aw_ready}); end
    tick();
    dn.b_valid = '0; up.b_ready = 1'b0;
    #1;
    n_checks++; if ({dn.aw_valid, up.aw_ready} !== 6'b00100_1) begin n_fail++;
      $display("[TB] FAIL ts_aw2: got %b expected 001001", {dn.aw_valid, up.aw_ready}); end
    tick();
    up.aw_valid = 1'b0; up.w_valid = 1'b1;
    #1;
    n_checks++; if (dn.w_valid !== 5'b00100) begin n_fail++;
      $display("[TB] FAIL ts_w2: got %b expected 00100", dn.w_valid); end
    tick();
    up.w_valid = 1'b0;
    dn.b_pl[2*B_W +: B_W] = {6'h02, 2'b00}; dn.b_valid = 5'b00100; up.b_ready = 1'b1;
    #1;
    n_checks++; if (up.b_pl !== {6'h02, 2'b00}) begin n_fail++;
      $display("[TB] FAIL ts_b2: got %h expected 08", up.b_pl); end
    tick();
    dn.b_valid = '0; up.b_ready = 1'b0;
    #1;
    n_checks++; if (dut.wr_cnt !== 4'd0) begin n_fail++;
      $display("[TB] FAIL ts_wr_cnt: got %0d expected 0", dut.wr_cnt); end
  endtask

  task automatic test_outstanding();
    dn.ar_ready = '1; up.r_ready = 1'b0; dn.r_pl = '0;
    up.ar_pl = mk_ax(64'h5000_0000, 6'h04, 8'd0); up.ar_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++; if ({dn.ar_valid, up.ar_ready} !== 6'b01000_1) begin n_fail++;
        $display("[TB] FAIL os_accept%0d: got %b expected 010001", k, {dn.ar_valid, up.ar_ready}); end
      tick();
    end
    #1;
    n_checks++; if ({dn.ar_valid, up.ar_ready} !== 6'b0) begin n_fail++;
      $display("[TB] FAIL os_ninth: got %b expected 000000", {dn.ar_valid, up.ar_ready}); end
    n_checks++; if (dut.rd_cnt !== 4'd8) begin n_fail++;
      $display("[TB] FAIL os_cnt8: got %0d expected 8", dut.rd_cnt); end
    tick();
    dn.r_pl[3*R_W +: R_W] = mk_r(6'h04, 2'b00, 1'b1); dn.r_valid = 5'b01000; up.r_ready = 1'b1;
    #1;
    n_checks++; if ({up.r_valid, dn.r_ready, up.ar_ready} !== 7'b1_01000_0) begin n_fail++;
      $display("[TB] FAIL os_rlast: got %b expected 1010000", {up.r_valid, dn.r_ready, up.ar_ready}); end
    tick();
    dn.r_valid = '0; up.r_ready = 1'b0;
    #1;
    n_checks++; if (up.ar_ready !== 1'b1) begin n_fail++;
      $display("[TB] FAIL os_resume: got %b expected 1", up.ar_ready); end
    tick();
    up.ar_valid = 1'b0;
    #1;
    n_checks++; if (dut.rd_cnt !== 4'd8) begin n_fail++;
      $display("[TB] FAIL os_refill: got %0d expected 8", dut.rd_cnt); end
  endtask

  task automatic test_simultaneous();
    dn.r_valid = 5'b01000; up.r_ready = 1'b1;
    repeat (4) tick();
    up.ar_valid = 1'b1;
    #1;
    n_checks++; if ({dut.rd_cnt, up.ar_ready, up.r_valid} !== {4'd4, 2'b11}) begin n_fail++;
      $display("[TB] FAIL sim_pre: got cnt=%0d ar_rdy=%b r_vld=%b expected 4/1/1", dut.rd_cnt, up.ar_ready, up.r_valid); end
    tick();
    up.ar_valid = 1'b0; dn.r_valid = '0; up.r_ready = 1'b0;
    #1;
    n_checks++; if (dut.rd_cnt !== 4'd4) begin n_fail++;
      $display("[TB] FAIL sim_rd_cnt: got %0d expected 4", dut.rd_cnt); end
    dn.r_valid = 5'b01000; up.r_ready = 1'b1;
    repeat (4) tick();
    dn.r_valid = '0; up.r_ready = 1'b0;
    #1;
    n_checks++; if (dut.rd_cnt !== 4'd0) begin n_fail++;
      $display("[TB] FAIL sim_drain: got %0d expected 0", dut.rd_cnt); end
    dn.aw_ready = '1; dn.w_ready = '1;
    up.aw_pl = mk_ax(64'h8000_0000, 6'h07, 8'd0); up.aw_valid = 1'b1;
    tick();
    up.w_pl = mk_w(64'h99, 1'b1); up.w_valid = 1'b1;
    #1;
    n_checks++; if ({dut.wf_cnt, up.aw_ready, up.w_ready} !== {4'd1, 2'b11}) begin n_fail++;
      $display("[TB] FAIL fifo_pre: got occ=%0d aw_rdy=%b w_rdy=%b expected 1/1/1", dut.wf_cnt, up.aw_ready, up.w_ready); end
    tick();
    up.aw_valid = 1'b0;
    #1;
    n_checks++; if (dut.wf_cnt !== 4'd1) begin n_fail++;
      $display("[TB] FAIL fifo_pushpop: got %0d expected 1", dut.wf_cnt); end
    tick();
    up.w_valid = 1'b0;
    #1;
    n_checks++; if ({dut.wf_cnt, dut.wr_cnt} !== {4'd0, 4'd2}) begin n_fail++;
      $display("[TB] FAIL fifo_drain: got occ=%0d cnt=%0d expected 0/2", dut.wf_cnt, dut.wr_cnt); end
    dn.b_pl[1*B_W +: B_W] = {6'h07, 2'b00}; dn.b_valid = 5'b00010; up.b_ready = 1'b1;
    tick(); tick();
    dn.b_valid = '0; up.b_ready = 1'b0;
    #1;
    n_checks++; if (dut.wr_cnt !== 4'd0) begin n_fail++;
      $display("[TB] FAIL fifo_b: got %0d expected 0", dut.wr_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    dn.aw_ready = '1; dn.w_ready = '1;
    up.aw_pl = mk_ax(64'h8000_0000, 6'h09, 8'd3); up.aw_valid = 1'b1;
    tick();
    up.aw_valid = 1'b0; up.w_pl = mk_w(64'h1, 1'b0); up.w_valid = 1'b1;
    tick();
    up.w_pl = mk_w(64'h2, 1'b0);
    #1;
    n_checks++; if (up.w_ready !== 1'b1) begin n_fail++;
      $display("[TB] FAIL rb_beat2: got %b expected 1", up.w_ready); end
    chipset_rstn = 1'b0;
    up.aw_pl = mk_ax(64'h4000_0000, 6'h0A, 8'd0); up.aw_valid = 1'b1;
    #1;
    n_checks++; if ({up.w_ready, dn.w_valid, up.aw_ready, dn.aw_valid} !== 12'b0) begin n_fail++;
      $display("[TB] FAIL rb_drop: got %b expected 0", {up.w_ready, dn.w_valid, up.aw_ready, dn.aw_valid}); end
    n_checks++; if ({dut.wr_cnt, dut.wf_cnt} !== 8'b0) begin n_fail++;
      $display("[TB] FAIL rb_state: got cnt=%0d occ=%0d expected 0/0", dut.wr_cnt, dut.wf_cnt); end
    up.w_valid = 1'b0; up.aw_valid = 1'b0;
    tick(); tick();
    chipset_rstn = 1'b1;
    tick();
    up.aw_valid = 1'b1;
    #1;
    n_checks++; if ({dn.aw_valid, up.aw_ready} !== 6'b00100_1) begin n_fail++;
      $display("[TB] FAIL rb_fresh_aw: got %b expected 001001", {dn.aw_valid, up.aw_ready}); end
    tick();
    up.aw_valid = 1'b0;
    #1;
    n_checks++; if (dut.wr_cnt !== 4'd1) begin n_fail++;
      $display("[TB] FAIL rb_fresh_cnt: got %0d expected 1", dut.wr_cnt); end
  endtask

  // Guards against a stuck run; should never fire.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chipset_rstn = 1'b0;
    up.aw_pl = '0; up.aw_valid = 1'b0; up.w_pl = '0; up.w_valid = 1'b0;
    up.b_ready = 1'b0; up.ar_pl = '0; up.ar_valid = 1'b0; up.r_ready = 1'b0;
    dn.aw_ready = '0; dn.w_ready = '0; dn.b_pl = '0; dn.b_valid = '0;
    dn.ar_ready = '0; dn.r_pl = '0; dn.r_valid = '0;
    test_reset();
    test_pass_through();
    test_unmapped_read();
    test_unmapped_write();
    test_target_switch();
    test_outstanding();
    test_simultaneous();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
